decoder_3_8_driver: RTL and testbench
=====================================

Name: decoder_3_8_driver

Overview:
Sequenced 3-to-8 one-hot decoder, the inverse of the 8-to-3 encoder.
- Accepts 3-bit codes over a valid/ready handshake.
- Drives the matching one-hot pattern on an 8-bit bus for HOLD_CYCLES, then a zero gap for GAP_CYCLES.
- Buffers one code while busy.
- A scan mode walks codes 0..7 autonomously; this is the stimulus source for encoder bring-up and loopback checks.

Parameters:
- HOLD_CYCLES, 4, cycles each one-hot pattern is held on out (legal range ≥1).
- GAP_CYCLES, 2, cycles of out=0 after each pattern (legal range ≥0).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_code  input  3  code to decode
- in_valid  input  1  in_code is valid
- in_ready  output  1  block can accept a code this cycle
- scan_start  input  1  single-cycle pulse; start an auto-scan of codes 0..7
- out  output  8  one-hot decoded pattern, or 0
- out_valid  output  1  out currently carries a pattern (DRIVE state)
- code_out  output  3  code currently driven; holds its last value outside DRIVE
- busy  output  1  state != IDLE or a scan is active
- done  output  1  one-cycle pulse when a scan completes

Behaviour:
- Reset, asynchronous and immediate: state=IDLE, out=0, out_valid=0, code_out=0, busy=0, done=0, pending buffer empty, scan_active=0, scan_idx=0, counter=0.
  - Reset mid-operation aborts the current pattern and scan.
  - Any pending code is discarded.
- States:
  - IDLE: out=0.
  - DRIVE: out = 1 << code_out, out_valid=1.
  - GAP: out=0.
- Handshake:
  - in_ready = !pending_valid && !scan_active (combinational).
  - A transfer occurs on a rising edge with in_valid && in_ready.
- Accept in IDLE:
  - Next state is DRIVE with code_out=in_code.
  - out is visible after the same edge (1-cycle latency).
  - The pending buffer is not used.
- Accept in DRIVE/GAP: code is stored in pending; in_ready drops to 0 until pending is consumed.
- DRIVE lasts exactly HOLD_CYCLES cycles. Counter counts 0..HOLD_CYCLES-1.
  - Then GAP if GAP_CYCLES>0.
  - Otherwise go straight to the "end of pattern" decision below.
- GAP lasts exactly GAP_CYCLES cycles, then the end-of-pattern decision:
  - If scan_active and scan_idx<7: scan_idx++ and DRIVE with the new index.
  - If scan_active and scan_idx==7: clear scan_active, pulse done for 1 cycle, go to IDLE.
  - Else if pending_valid: DRIVE with the pending code and clear pending on the same edge. There is no idle cycle between back-to-back codes.
  - Else go to IDLE.
- Scan start: scan_start is honoured only in IDLE with pending empty.
  - Sets scan_active=1, scan_idx=0, enters DRIVE with code 0.
  - scan_start outside IDLE is ignored; it is not queued.
- Simultaneous in_valid and scan_start in IDLE: the in_valid transfer wins and scan_start is ignored.
- Timing per pattern: HOLD_CYCLES+GAP_CYCLES cycles. A full scan takes 8*(HOLD+GAP) cycles. done asserts on the first IDLE cycle after the last gap.
- Counter width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). The counter resets to 0 on every state transition.
- Invariant: out is either 0 or has exactly one bit set. out != 0 iff out_valid.

Decomposition:
- Package decoder_pkg:
  - CODE_W=3, ONEHOT_W=8.
  - typedef enum logic [1:0] {IDLE, DRIVE, GAP} dec_state_t.
  - typedef logic [CODE_W-1:0] code_t.
- Sub-module decoder_3_8_core: purely combinational. Maps code_t plus an enable to an 8-bit one-hot output, 0 when disabled. out is driven through it, enabled by (state==DRIVE).

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=2):
- Reset asserted mid-DRIVE of code 5 → out=8'h00, out_valid=0, busy=0 immediately, before the next clk edge. After release: in_ready=1, no residual pattern.
- Single code 3 accepted in IDLE at edge N → out=8'b0000_1000 for edges N..N+3. out=0 for 2 cycles. IDLE and busy=0 from edge N+6.
- Codes 1 then 6 sent back-to-back:
  - in_ready=0 after the second accept.
  - out=8'h02 ×4, 8'h00 ×2, 8'h40 ×4 with no IDLE cycle between.
  - in_ready=1 again once 6 starts driving.
- scan_start pulse in IDLE → out sequence 8'h01,8'h02,…,8'h80, each held 4 cycles with 2-cycle zero gaps.
  - in_ready=0 throughout.
  - done=1 for exactly one cycle, 48 cycles after start.
- scan_start during DRIVE of code 2 → ignored: no scan, done never pulses, out returns to 0 after code 2 completes.
- Same-cycle in_valid (code 7) and scan_start in IDLE → code 7 driven (out=8'h80), scan_active stays 0, done never asserts.
- Loopback check: drive out into encoder_8_3 → encoder output equals code_out on every out_valid cycle of a full scan.

Source files
------------

// File: rtl/decoder_3_8_driver_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared types and constants for the sequenced 3-to-8 decoder driver.
//   CODE_W / ONEHOT_W : width of a binary code and of its one-hot pattern
//   dec_state_t       : sequencer states (IDLE, DRIVE, GAP)
//   code_t / onehot_t : bus types used by the interface and the datapath
//   cnt_width()       : width of the shared hold/gap cycle counter
// -----------------------------------------------------------------------------
package decoder_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } dec_state_t;

    typedef logic [CODE_W-1:0]   code_t;
    typedef logic [ONEHOT_W-1:0] onehot_t;

    // Highest code; an auto-scan ends after this code's gap.
    localparam code_t LAST_CODE = code_t'(ONEHOT_W - 1);

    // One counter serves both DRIVE and GAP, so it must hold the larger
    // of the two terminal counts.
    function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
        int max_cycles;
        max_cycles = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/decoder_3_8_driver_if.sv
// -----------------------------------------------------------------------------
// decoder_3_8_driver_if
// Bundles the code handshake, the scan control and the decoded output bus.
//   in_code/in_valid/in_ready : code transfer, happens when valid && ready
//   scan_start                : one-cycle request for an auto-scan of 0..7
//   out/out_valid/code_out    : one-hot pattern, its qualifier, its code
//   busy/done                 : activity flag and scan-complete pulse
// Modports: master = code/scan source, slave = decoder driver.
// -----------------------------------------------------------------------------
interface decoder_3_8_driver_if;
    import decoder_pkg::*;

    code_t   in_code;
    logic    in_valid;
    logic    in_ready;
    logic    scan_start;
    onehot_t out;
    logic    out_valid;
    code_t   code_out;
    logic    busy;
    logic    done;

    modport master (
        output in_code, in_valid, scan_start,
        input  in_ready, out, out_valid, code_out, busy, done
    );

    modport slave (
        input  in_code, in_valid, scan_start,
        output in_ready, out, out_valid, code_out, busy, done
    );

endinterface

// File: rtl/decoder_3_8_driver_core.sv
// -----------------------------------------------------------------------------
// decoder_3_8_core
// Purely combinational 3-to-8 one-hot decoder with enable.
//   code_i   : binary code to decode
//   en_i     : when low the output is forced to zero
//   onehot_o : 1 << code_i when enabled, otherwise 0
// -----------------------------------------------------------------------------
module decoder_3_8_core
    import decoder_pkg::*;
(
    input  code_t   code_i,
    input  logic    en_i,
    output onehot_t onehot_o
);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves it unassigned would infer a latch.
        onehot_o = '0;
        if (en_i) begin
            onehot_o[code_i] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_3_8_driver.sv
// -----------------------------------------------------------------------------
// decoder_3_8_driver
// Sequenced 3-to-8 one-hot decoder. Each accepted code is shown on the
// output bus as a one-hot pattern for HOLD_CYCLES cycles, followed by
// GAP_CYCLES cycles of zero. One code can be buffered while a pattern is in
// progress. A scan_start pulse in IDLE walks codes 0..7 on its own and
// pulses done on the first IDLE cycle after the last gap.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : decoder_3_8_driver_if.slave (handshake, scan control, outputs)
// Parameters:
//   HOLD_CYCLES : cycles each pattern is held (>= 1)
//   GAP_CYCLES  : zero cycles after each pattern (>= 0)
// -----------------------------------------------------------------------------
module decoder_3_8_driver
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    decoder_3_8_driver_if.slave  bus
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);
    // With no gap the GAP state is never entered, so its terminal count
    // only needs to be a legal value.
    localparam cnt_t GAP_LAST  = cnt_t'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // ---------------------------------------------------------------- state
    dec_state_t state_q,       state_d;
    cnt_t       cnt_q,         cnt_d;
    code_t      code_q,        code_d;
    logic       pend_valid_q,  pend_valid_d;
    code_t      pend_code_q,   pend_code_d;
    logic       scan_active_q, scan_active_d;
    code_t      scan_idx_q,    scan_idx_d;
    logic       done_q,        done_d;

    logic       in_ready;
    logic       accept;
    logic       pattern_end;

    // A new code is refused only while the buffer is full or a scan owns
    // the output.
    assign in_ready = !pend_valid_q && !scan_active_q;
    assign accept   = bus.in_valid && in_ready;

    // ------------------------------------------------------- state register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, and the
        // asynchronous reset returns every register to a known value.
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            code_q        <= '0;
            pend_valid_q  <= 1'b0;
            pend_code_q   <= '0;
            scan_active_q <= 1'b0;
            scan_idx_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            code_q        <= code_d;
            pend_valid_q  <= pend_valid_d;
            pend_code_q   <= pend_code_d;
            scan_active_q <= scan_active_d;
            scan_idx_q    <= scan_idx_d;
            done_q        <= done_d;
        end
    end

    // ------------------------------------------------ next-state decisions
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + cnt_t'(1);
        code_d        = code_q;
        pend_valid_d  = pend_valid_q;
        pend_code_d   = pend_code_q;
        scan_active_d = scan_active_q;
        scan_idx_d    = scan_idx_q;
        done_d        = 1'b0;
        pattern_end   = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // A real code transfer takes priority over a scan request.
                if (accept) begin
                    state_d = DRIVE;
                    code_d  = bus.in_code;
                end else if (bus.scan_start) begin
                    state_d       = DRIVE;
                    code_d        = '0;
                    scan_active_d = 1'b1;
                    scan_idx_d    = '0;
                end
            end

            DRIVE: begin
                if (cnt_q == HOLD_LAST) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        pattern_end = 1'b1;
                    end
                end
            end

            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    pattern_end = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A code arriving mid-pattern is parked until the pattern finishes.
        if ((state_q != IDLE) && accept && !pattern_end) begin
            pend_valid_d = 1'b1;
            pend_code_d  = bus.in_code;
        end

        // End of a pattern: continue the scan, replay the parked code, or
        // take a code offered on this very edge, so that back-to-back codes
        // never see an idle cycle between them.
        if (pattern_end) begin
            cnt_d = '0;
            if (scan_active_q) begin
                if (scan_idx_q != LAST_CODE) begin
                    state_d    = DRIVE;
                    scan_idx_d = scan_idx_q + code_t'(1);
                    code_d     = scan_idx_q + code_t'(1);
                end else begin
                    state_d       = IDLE;
                    scan_active_d = 1'b0;
                    scan_idx_d    = '0;
                    done_d        = 1'b1;
                end
            end else if (pend_valid_q) begin
                state_d      = DRIVE;
                code_d       = pend_code_q;
                pend_valid_d = 1'b0;
            end else if (accept) begin
                state_d = DRIVE;
                code_d  = bus.in_code;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    decoder_3_8_core u_core (
        .code_i   (code_q),
        .en_i     (state_q == DRIVE),
        .onehot_o (bus.out)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DRIVE);
    assign bus.code_out  = code_q;
    assign bus.busy      = (state_q != IDLE) || scan_active_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_decoder_3_8_driver.sv
// -----------------------------------------------------------------------------
// tb_decoder_3_8_driver
// Self-checking bench for decoder_3_8_driver (HOLD_CYCLES=4, GAP_CYCLES=2).
// A behavioural model tracks each pattern as "started at edge t with code c"
// and derives the expected outputs from the offset since t.
// -----------------------------------------------------------------------------
module tb_decoder_3_8_driver;
    import decoder_pkg::*;

    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam int PAT  = HOLD + GAP;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    decoder_3_8_driver_if bus ();

    decoder_3_8_driver #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------ reference model
    bit         m_act;
    int         m_off;
    logic [2:0] m_code;
    bit         m_pend;
    logic [2:0] m_pend_code;
    bit         m_scan;
    int         m_scan_idx;
    bit         m_done;

    task automatic model_reset();
        m_act = 0; m_off = 0; m_code = '0; m_pend = 0; m_pend_code = '0;
        m_scan = 0; m_scan_idx = 0; m_done = 0;
    endtask

    task automatic model_start(input logic [2:0] c);
        m_act  = 1;
        m_off  = 0;
        m_code = c;
    endtask

    // Expected {out, out_valid, code_out, busy, done, in_ready}.
    function automatic logic [14:0] model_vec();
        logic       v;
        logic [7:0] o;
        v = m_act && (m_off < HOLD);
        o = v ? (8'd1 << m_code) : 8'd0;
        return {o, v, m_code, (m_act || m_scan), m_done, (!m_pend && !m_scan)};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {bus.out, bus.out_valid, bus.code_out, bus.busy, bus.done, bus.in_ready};
    endfunction

    // Reference 8-to-3 encoder for loopback: index of the set bit.
    function automatic logic [2:0] encode(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            if (v[b]) r = 3'(b);
        end
        return r;
    endfunction

    // Advance one clock edge (inputs already set), update the model with
    // the inputs seen at that edge, and return on the following falling edge.
    task automatic tick();
        bit         acc;
        logic [2:0] c;
        acc = bus.in_valid && !m_pend && !m_scan;
        c   = bus.in_code;
        @(posedge clk);
        m_done = 0;
        if (m_act) begin
            m_off++;
            if (m_off == PAT) begin
                if (m_scan && m_scan_idx < 7) begin
                    m_scan_idx++;
                    model_start(3'(m_scan_idx));
                end else if (m_scan) begin
                    m_scan = 0; m_scan_idx = 0; m_done = 1; m_act = 0;
                end else if (m_pend) begin
                    model_start(m_pend_code);
                    m_pend = 0;
                end else if (acc) begin
                    model_start(c);
                end else begin
                    m_act = 0;
                end
            end else if (acc) begin
                m_pend = 1;
                m_pend_code = c;
            end
        end else if (acc) begin
            model_start(c);
        end else if (bus.scan_start) begin
            m_scan = 1; m_scan_idx = 0;
            model_start(3'd0);
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.in_valid = 1'b0; bus.in_code = '0; bus.scan_start = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [14:0] got;
        got = dut_vec();
        n_checks++;
        if (got !== 15'b0000_0000_0_000_0_0_1) begin
            n_fail++; $display("FAIL reset_state got=%h exp=%h", got, 15'b0000_0000_0_000_0_0_1);
        end
        bus.in_code = 3'd5; bus.in_valid = 1'b1;
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (bus.out !== 8'h20) begin
            n_fail++; $display("FAIL reset_pre_out got=%h exp=%h", bus.out, 8'h20);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({bus.out, bus.out_valid, bus.busy} !== 10'b0) begin
            n_fail++; $display("FAIL reset_async out=%h out_valid=%b busy=%b exp all zero",
                               bus.out, bus.out_valid, bus.busy);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        got = dut_vec();
        n_checks++;
        if (got !== model_vec() || bus.in_ready !== 1'b1 || bus.out !== 8'h00) begin
            n_fail++; $display("FAIL reset_release got=%h exp=%h", got, model_vec());
        end
    endtask

    task automatic test_single();
        bus.in_code = 3'd3; bus.in_valid = 1'b1;
        tick();
        clear_inputs();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] exp_out;
            exp_out = (k < HOLD) ? 8'b0000_1000 : 8'h00;
            n_checks++;
            if (bus.out !== exp_out || bus.busy !== (k < PAT)) begin
                n_fail++; $display("FAIL single k=%0d out=%h exp=%h busy=%b", k, bus.out, exp_out, bus.busy);
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL single_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_out [14];
        logic       exp_rdy;
        for (int k = 0; k < 14; k++) begin
            if (k < 4)       exp_out[k] = 8'h02;
            else if (k < 6)  exp_out[k] = 8'h00;
            else if (k < 10) exp_out[k] = 8'h40;
            else             exp_out[k] = 8'h00;
        end
        for (int k = 0; k < 14; k++) begin
            bus.in_valid = (k < 2);
            bus.in_code  = (k == 0) ? 3'd1 : 3'd6;
            tick();
            clear_inputs();
            exp_rdy = !(k >= 1 && k <= 5);
            n_checks++;
            if (bus.out !== exp_out[k] || bus.in_ready !== exp_rdy || bus.busy !== (k < 12)) begin
                n_fail++; $display("FAIL b2b k=%0d out=%h exp=%h ready=%b exp=%b busy=%b",
                                   k, bus.out, exp_out[k], bus.in_ready, exp_rdy, bus.busy);
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL b2b_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_scan();
        int n_done;
        n_done = 0;
        bus.scan_start = 1'b1;
        tick();
        clear_inputs();
        for (int k = 0; k < 52; k++) begin
            logic [7:0] exp_out;
            exp_out = (k < 8 * PAT && (k % PAT) < HOLD) ? (8'd1 << (k / PAT)) : 8'h00;
            if (bus.done === 1'b1) n_done++;
            n_checks++;
            if (bus.out !== exp_out || bus.in_ready !== (k >= 8 * PAT) || bus.done !== (k == 8 * PAT)) begin
                n_fail++; $display("FAIL scan k=%0d out=%h exp=%h ready=%b done=%b",
                                   k, bus.out, exp_out, bus.in_ready, bus.done);
            end
            if (bus.out_valid === 1'b1) begin
                n_checks++;
                if (encode(bus.out) !== bus.code_out) begin
                    n_fail++; $display("FAIL loopback k=%0d enc=%0d code_out=%0d", k, encode(bus.out), bus.code_out);
                end
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL scan_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            tick();
        end
        n_checks++;
        if (n_done != 1) begin
            n_fail++; $display("FAIL scan_done_count got=%0d exp=1", n_done);
        end
    endtask

    task automatic test_scan_ignored();
        bit saw_done;
        saw_done = 0;
        bus.in_code = 3'd2; bus.in_valid = 1'b1;
        tick();
        clear_inputs();
        tick();
        bus.scan_start = 1'b1;
        tick();
        clear_inputs();
        for (int k = 0; k < 12; k++) begin
            if (bus.done !== 1'b0) saw_done = 1;
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL scan_ign_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            tick();
        end
        n_checks++;
        if (saw_done || bus.out !== 8'h00 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL scan_ignored done_seen=%b out=%h busy=%b ready=%b exp 0/00/0/1",
                               saw_done, bus.out, bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_simultaneous();
        bit saw_done;
        saw_done = 0;
        bus.in_code = 3'd7; bus.in_valid = 1'b1; bus.scan_start = 1'b1;
        tick();
        clear_inputs();
        n_checks++;
        if (bus.out !== 8'h80 || bus.code_out !== 3'd7 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL simul_start out=%h exp=80 code=%0d ready=%b", bus.out, bus.code_out, bus.in_ready);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.done !== 1'b0) saw_done = 1;
        end
        n_checks++;
        if (saw_done || bus.busy !== 1'b0 || bus.out !== 8'h00) begin
            n_fail++; $display("FAIL simul_end done_seen=%b busy=%b out=%h exp 0/0/00", saw_done, bus.busy, bus.out);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            bus.in_valid   = ($urandom_range(0, 2) == 0);
            bus.in_code    = 3'($urandom_range(0, 7));
            bus.scan_start = ($urandom_range(0, 29) == 0);
            tick();
            clear_inputs();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            n_checks++;
            if (((bus.out & (bus.out - 8'd1)) !== 8'h00) || ((bus.out !== 8'h00) !== bus.out_valid)) begin
                n_fail++; $display("FAIL onehot_inv k=%0d out=%h out_valid=%b", k, bus.out, bus.out_valid);
            end
        end
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        clear_inputs();
        model_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_scan();
        test_scan_ignored();
        test_simultaneous();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
